// File: rtl/frame_renderer.sv
// frame_renderer
//
// Paints one 160x120 frame. A start request snapshots the game object
// positions, then the block enables the external coordinate counter.
// Every coordinate the counter presents is classified against the snapshot.
// The result goes to the VGA adapter as a registered write, one cycle later.
//
// Ports
//   clock, reset        : rising-edge clock; asynchronous active-high reset
//   start               : frame request (see handshake note below)
//   tank1_x/y, tank2_x/y: tank top-left corners
//   bullet_x/y          : bullet top-left corner
//   bullet_active       : bullet visibility
//   cnt_x/y, cnt_done   : coordinate counter stream (scan source)
//   cnt_enable          : enable for the coordinate counter
//   vga_x/y, colour     : pixel write to the VGA adapter
//   plot                : write strobe for the VGA adapter
//   busy                : a frame is in progress
//   frame_done          : one-cycle pulse after the last write
//   state_dbg           : current FSM state (1 = SCAN), for checkers
//
// Handshake: start is a single-cycle request with no ready signal.
//   - It is accepted on the rising edge only while busy is low (IDLE).
//   - Once accepted, busy rises in the next cycle.
//   - A start seen while busy is high is dropped, not queued.
//   - A start in the frame_done cycle is accepted, because the FSM is
//     already back in IDLE in that cycle.
//   - plot is a pure strobe. The adapter cannot stall the scan.

module frame_renderer #(
    parameter int GROUND_Y = 112,
    parameter int TANK_W   = 8,
    parameter int TANK_H   = 6,
    parameter int BULLET_S = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tank1_x,
    input  logic [6:0] tank1_y,
    input  logic [7:0] tank2_x,
    input  logic [6:0] tank2_y,
    input  logic [7:0] bullet_x,
    input  logic [6:0] bullet_y,
    input  logic       bullet_active,
    input  logic [7:0] cnt_x,
    input  logic [6:0] cnt_y,
    input  logic       cnt_done,
    output logic       cnt_enable,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       frame_done,
    output logic       state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [8:0] TANK_W9   = 9'(TANK_W);
    localparam logic [7:0] TANK_H8   = 8'(TANK_H);
    localparam logic [8:0] BULLET_W9 = 9'(BULLET_S);
    localparam logic [7:0] BULLET_H8 = 8'(BULLET_S);
    localparam logic [6:0] GROUND_Y7 = 7'(GROUND_Y);

    localparam logic [2:0] C_WHITE = 3'b111;
    localparam logic [2:0] C_RED   = 3'b100;
    localparam logic [2:0] C_BLUE  = 3'b001;
    localparam logic [2:0] C_GREEN = 3'b010;
    localparam logic [2:0] C_BLACK = 3'b000;

    state_t     state, state_n;

    logic       cnt_enable_n;
    logic       busy_n;
    logic       plot_n;
    logic       frame_done_n;
    logic [7:0] vga_x_n;
    logic [6:0] vga_y_n;
    logic [2:0] colour_n;
    logic       snap_load;

    // Snapshot of object positions, frozen for the whole frame.
    logic [7:0] s_tank1_x, s_tank2_x, s_bullet_x;
    logic [6:0] s_tank1_y, s_tank2_y, s_bullet_y;
    logic       s_bullet_active;

    logic       bullet_hit, tank1_hit, tank2_hit, ground_hit;
    logic [2:0] pix_colour;

    // The offset is taken one bit wider than the coordinate, after x >= ox
    // has been checked. A box near the right or bottom edge therefore only
    // clips. It can never wrap back onto column 0 or row 0.
    function automatic logic hit_x(input logic [7:0] x, input logic [7:0] ox,
                                   input logic [8:0] w);
        logic [8:0] dx;
        dx = {1'b0, x} - {1'b0, ox};
        return (x >= ox) && (dx < w);
    endfunction

    function automatic logic hit_y(input logic [6:0] y, input logic [6:0] oy,
                                   input logic [7:0] h);
        logic [7:0] dy;
        dy = {1'b0, y} - {1'b0, oy};
        return (y >= oy) && (dy < h);
    endfunction

    assign bullet_hit = s_bullet_active
                        && hit_x(cnt_x, s_bullet_x, BULLET_W9)
                        && hit_y(cnt_y, s_bullet_y, BULLET_H8);
    assign tank1_hit  = hit_x(cnt_x, s_tank1_x, TANK_W9)
                        && hit_y(cnt_y, s_tank1_y, TANK_H8);
    assign tank2_hit  = hit_x(cnt_x, s_tank2_x, TANK_W9)
                        && hit_y(cnt_y, s_tank2_y, TANK_H8);
    assign ground_hit = (cnt_y >= GROUND_Y7);

    always_comb begin
        if (bullet_hit)      pix_colour = C_WHITE;
        else if (tank1_hit)  pix_colour = C_RED;
        else if (tank2_hit)  pix_colour = C_BLUE;
        else if (ground_hit) pix_colour = C_GREEN;
        else                 pix_colour = C_BLACK;
    end

    // Next-state and next-output logic. Write-port values hold by default.
    // plot and frame_done are strobes and default low.
    always_comb begin
        state_n      = state;
        cnt_enable_n = cnt_enable;
        busy_n       = busy;
        plot_n       = 1'b0;
        frame_done_n = 1'b0;
        vga_x_n      = vga_x;
        vga_y_n      = vga_y;
        colour_n     = colour;
        snap_load    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n      = SCAN;
                    cnt_enable_n = 1'b1;
                    busy_n       = 1'b1;
                    snap_load    = 1'b1;
                end
            end
            SCAN: begin
                if (cnt_done) begin
                    // The counter holds its last coordinate while done is
                    // high. That coordinate was already written in the
                    // previous cycle, so nothing is written here.
                    state_n      = IDLE;
                    cnt_enable_n = 1'b0;
                    busy_n       = 1'b0;
                    frame_done_n = 1'b1;
                end else begin
                    plot_n   = 1'b1;
                    vga_x_n  = cnt_x;
                    vga_y_n  = cnt_y;
                    colour_n = pix_colour;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt_enable      <= 1'b0;
            busy            <= 1'b0;
            plot            <= 1'b0;
            frame_done      <= 1'b0;
            vga_x           <= '0;
            vga_y           <= '0;
            colour          <= '0;
            s_tank1_x       <= '0;
            s_tank1_y       <= '0;
            s_tank2_x       <= '0;
            s_tank2_y       <= '0;
            s_bullet_x      <= '0;
            s_bullet_y      <= '0;
            s_bullet_active <= 1'b0;
        end else begin
            state      <= state_n;
            cnt_enable <= cnt_enable_n;
            busy       <= busy_n;
            plot       <= plot_n;
            frame_done <= frame_done_n;
            vga_x      <= vga_x_n;
            vga_y      <= vga_y_n;
            colour     <= colour_n;
            if (snap_load) begin
                s_tank1_x       <= tank1_x;
                s_tank1_y       <= tank1_y;
                s_tank2_x       <= tank2_x;
                s_tank2_y       <= tank2_y;
                s_bullet_x      <= bullet_x;
                s_bullet_y      <= bullet_y;
                s_bullet_active <= bullet_active;
            end
        end
    end

    assign state_dbg = (state == SCAN);

endmodule

// File: tb/tb_frame_renderer.sv
// tb_frame_renderer
//
// Bench for frame_renderer with a behavioural model of the coordinate
// counter as the scan source.
//
// Expected results come from three sources:
//   - Every write is checked against a pixel-order and latency model.
//   - Every write is also checked against a colour queue. The queue is
//     built from a reference classifier when the frame starts.
//   - A table of hand-computed points is checked after each frame.

module tb_frame_renderer;

    typedef struct {
        int t1x; int t1y;
        int t2x; int t2y;
        int bx;  int by;
        bit ba;
    } pos_t;

    typedef struct {
        int         frame;
        int         x;
        int         y;
        logic [2:0] exp;
    } pt_t;

    localparam int NPIX = 19200;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic       start;
    logic [7:0] tank1_x, tank2_x, bullet_x;
    logic [6:0] tank1_y, tank2_y, bullet_y;
    logic       bullet_active;
    logic [7:0] cnt_x = '0;
    logic [6:0] cnt_y = '0;
    logic       cnt_done = 1'b0;
    logic       cnt_enable;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot, busy, frame_done, state_dbg;

    frame_renderer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .tank1_x      (tank1_x),
        .tank1_y      (tank1_y),
        .tank2_x      (tank2_x),
        .tank2_y      (tank2_y),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .bullet_active(bullet_active),
        .cnt_x        (cnt_x),
        .cnt_y        (cnt_y),
        .cnt_done     (cnt_done),
        .cnt_enable   (cnt_enable),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .colour       (colour),
        .plot         (plot),
        .busy         (busy),
        .frame_done   (frame_done),
        .state_dbg    (state_dbg)
    );

    // Coordinate counter model: clears while disabled, advances in raster
    // order while enabled, raises done after the last pixel and holds it.
    always @(posedge clock) begin
        if (!cnt_enable) begin
            cnt_x    <= '0;
            cnt_y    <= '0;
            cnt_done <= 1'b0;
        end else if (!cnt_done) begin
            if (cnt_x == 8'd159 && cnt_y == 7'd119) begin
                cnt_done <= 1'b1;
            end else if (cnt_x == 8'd159) begin
                cnt_x <= '0;
                cnt_y <= cnt_y + 7'd1;
            end else begin
                cnt_x <= cnt_x + 8'd1;
            end
        end
    end

    // ---------------- scoreboard state ----------------
    int         errors = 0;
    int         checks = 0;
    logic [2:0] exp_q[$];
    logic [2:0] fb [NPIX];
    int         plot_cnt, order_err, model_err, done_cnt, done_cyc, s_cyc;
    bit         in_frame;
    pos_t       snap;
    pt_t        pts[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit in_rect(input int x, input int y, input int ox,
                                   input int oy, input int w, input int h);
        return (x >= ox) && (x < ox + w) && (y >= oy) && (y < oy + h);
    endfunction

    function automatic logic [2:0] ref_colour(input int x, input int y,
                                              input pos_t p);
        if (p.ba && in_rect(x, y, p.bx, p.by, 2, 2)) return 3'b111;
        if (in_rect(x, y, p.t1x, p.t1y, 8, 6))       return 3'b100;
        if (in_rect(x, y, p.t2x, p.t2y, 8, 6))       return 3'b001;
        if (y >= 112)                                return 3'b010;
        return 3'b000;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_pos(input pos_t p);
        tank1_x       = 8'(p.t1x);
        tank1_y       = 7'(p.t1y);
        tank2_x       = 8'(p.t2x);
        tank2_y       = 7'(p.t2y);
        bullet_x      = 8'(p.bx);
        bullet_y      = 7'(p.by);
        bullet_active = p.ba;
    endtask

    // Monitor, called once per cycle on the falling edge.
    task automatic sample();
        logic [2:0] e;
        if (plot) begin
            if (plot_cnt < NPIX) begin
                if (int'(vga_x) != plot_cnt % 160 || int'(vga_y) != plot_cnt / 160
                    || cyc != s_cyc + 2 + plot_cnt)
                    order_err++;
                fb[plot_cnt] = colour;
            end else begin
                order_err++;
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (colour != e) model_err++;
            end else begin
                model_err++;
            end
            plot_cnt++;
        end
        if (in_frame && cyc > s_cyc && cyc < s_cyc + 19202 && !(busy && cnt_enable))
            order_err++;
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
            in_frame = 1'b0;
            if (plot || busy || cnt_enable) order_err++;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        sample();
    endtask

    // Raise start for the coming edge. The current cycle becomes S.
    task automatic begin_frame(input pos_t p);
        set_pos(p);
        snap      = p;
        start     = 1'b1;
        s_cyc     = cyc;
        plot_cnt  = 0;
        order_err = 0;
        model_err = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        in_frame  = 1'b1;
        exp_q.delete();
        for (int k = 0; k < NPIX; k++) exp_q.push_back(ref_colour(k % 160, k / 160, p));
    endtask

    // Runs until frame_done, until cycle S+stop_at, or until the budget.
    // At S+change_at the inputs change and a start is pulsed.
    task automatic run_frame(input int change_at, input pos_t p_change, input int stop_at);
        tick();
        start = 1'b0;
        check("enable_at_S+1", int'(cnt_enable), 1);
        check("busy_at_S+1", int'(busy), 1);
        while (done_cnt == 0 && cyc < s_cyc + 19300) begin
            if (stop_at > 0 && cyc >= s_cyc + stop_at) return;
            if (change_at > 0 && cyc == s_cyc + change_at) begin
                set_pos(p_change);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic check_points(input int f);
        foreach (pts[i]) begin
            if (pts[i].frame == f)
                check($sformatf("f%0d_pix(%0d,%0d)", f, pts[i].x, pts[i].y),
                      int'(fb[pts[i].y * 160 + pts[i].x]), int'(pts[i].exp));
        end
    endtask

    task automatic end_frame_checks(input int f);
        check($sformatf("f%0d_done_cycle_offset", f), done_cyc - s_cyc, 19202);
        check($sformatf("f%0d_plot_count", f), plot_cnt, NPIX);
        check($sformatf("f%0d_order_errors", f), order_err, 0);
        check($sformatf("f%0d_colour_errors", f), model_err, 0);
        check($sformatf("f%0d_exp_left", f), exp_q.size(), 0);
        check_points(f);
    endtask

    // ---------------- test ----------------
    pos_t pa, pb, pd, pe;

    initial begin
        pa = '{0, 0, 0, 0, 0, 0, 1'b0};
        pb = '{20, 30, 100, 50, 22, 31, 1'b1};
        pd = '{20, 30, 40, 20, 22, 31, 1'b0};
        pe = '{156, 117, 100, 50, 150, 100, 1'b1};

        // frame 1: everything at the origin, bullet hidden
        pts.push_back('{1, 0, 0, 3'b100});
        pts.push_back('{1, 3, 3, 3'b100});
        pts.push_back('{1, 7, 5, 3'b100});
        pts.push_back('{1, 8, 0, 3'b000});
        pts.push_back('{1, 0, 6, 3'b000});
        pts.push_back('{1, 7, 6, 3'b000});
        pts.push_back('{1, 159, 111, 3'b000});
        pts.push_back('{1, 0, 112, 3'b010});
        pts.push_back('{1, 80, 115, 3'b010});
        pts.push_back('{1, 159, 119, 3'b010});
        // frame 2: tanks apart, bullet over tank 1
        pts.push_back('{2, 20, 30, 3'b100});
        pts.push_back('{2, 27, 35, 3'b100});
        pts.push_back('{2, 28, 30, 3'b000});
        pts.push_back('{2, 20, 36, 3'b000});
        pts.push_back('{2, 100, 50, 3'b001});
        pts.push_back('{2, 107, 55, 3'b001});
        pts.push_back('{2, 108, 55, 3'b000});
        pts.push_back('{2, 22, 31, 3'b111});
        pts.push_back('{2, 23, 32, 3'b111});
        pts.push_back('{2, 24, 31, 3'b100});
        pts.push_back('{2, 22, 33, 3'b100});
        pts.push_back('{2, 21, 31, 3'b100});
        // frame 3: bullet hidden, tank 2 moved; all points before pixel 7000
        pts.push_back('{3, 22, 31, 3'b100});
        pts.push_back('{3, 23, 32, 3'b100});
        pts.push_back('{3, 40, 20, 3'b001});
        pts.push_back('{3, 47, 25, 3'b001});
        pts.push_back('{3, 48, 20, 3'b000});
        pts.push_back('{3, 40, 26, 3'b000});
        // frame 4: tank 1 clipped at the bottom-right corner
        pts.push_back('{4, 156, 117, 3'b100});
        pts.push_back('{4, 159, 117, 3'b100});
        pts.push_back('{4, 156, 119, 3'b100});
        pts.push_back('{4, 159, 119, 3'b100});
        pts.push_back('{4, 155, 117, 3'b010});
        pts.push_back('{4, 0, 117, 3'b010});
        pts.push_back('{4, 0, 118, 3'b010});
        pts.push_back('{4, 156, 0, 3'b000});
        pts.push_back('{4, 157, 1, 3'b000});
        pts.push_back('{4, 150, 100, 3'b111});
        pts.push_back('{4, 151, 101, 3'b111});
        pts.push_back('{4, 152, 100, 3'b000});
        pts.push_back('{4, 100, 50, 3'b001});

        start     = 1'b0;
        plot_cnt  = 0;
        order_err = 0;
        model_err = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        s_cyc     = 0;
        in_frame  = 1'b0;
        snap      = pa;
        set_pos(pa);

        // reset state
        tick();
        tick();
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cnt_enable", int'(cnt_enable), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_vga_x", int'(vga_x), 0);
        check("rst_vga_y", int'(vga_y), 0);
        check("rst_colour", int'(colour), 0);
        check("rst_state", int'(state_dbg), 0);
        reset = 1'b0;
        tick();
        tick();

        // frame 1
        begin_frame(pa);
        run_frame(0, pa, 0);
        end_frame_checks(1);
        tick();
        tick();
        tick();
        check("f1_single_done_pulse", done_cnt, 1);
        check("f1_no_extra_plot", plot_cnt, NPIX);

        // frame 2: mid-frame start with new positions must be ignored
        begin_frame(pb);
        run_frame(5000, pd, 0);
        end_frame_checks(2);

        // frame 3: start in the frame_done cycle, then reset at S+7000
        begin_frame(pd);
        run_frame(0, pd, 7000);
        check("f3_reset_cycle_offset", cyc - s_cyc, 7000);
        check("f3_plot_before_reset", int'(plot), 1);
        reset = 1'b1;
        #1;
        check("f3_plot_async_clear", int'(plot), 0);
        check("f3_busy_async_clear", int'(busy), 0);
        check("f3_enable_async_clear", int'(cnt_enable), 0);
        check("f3_state_async_clear", int'(state_dbg), 0);
        check("f3_colour_async_clear", int'(colour), 0);
        in_frame = 1'b0;
        check("f3_plot_count", plot_cnt, 6999);
        check("f3_order_errors", order_err, 0);
        check("f3_colour_errors", model_err, 0);
        check_points(3);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("f3_no_done_after_reset", done_cnt, 0);
        check("f3_no_plot_after_reset", plot_cnt, 6999);

        // frame 4: complete frame after the reset
        begin_frame(pe);
        run_frame(0, pe, 0);
        end_frame_checks(4);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_renderer.md
# frame_renderer

Per-frame pixel painter for the 160x120 game screen. On a `start` pulse it snapshots the game object positions, drives the `enable` input of the screen coordinate counter, consumes the counter's `x`/`y`/`done` stream, and emits one registered VGA write (`plot`, `vga_x`, `vga_y`, `colour`) per screen coordinate. It sits between the game logic, upstream, and the VGA adapter, downstream, with the coordinate counter as its scan source.

## Interface
Parameters:
- `GROUND_Y`, default 112: first row of the ground band.
- `TANK_W`, default 8: tank box width in pixels.
- `TANK_H`, default 6: tank box height in pixels.
- `BULLET_S`, default 2: bullet square side in pixels.

Ports:
- `clock` input 1: single clock; all state on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: one-cycle request to render a frame; ignored while `busy`.
- `tank1_x` input 8, `tank1_y` input 7: tank 1 top-left corner.
- `tank2_x` input 8, `tank2_y` input 7: tank 2 top-left corner.
- `bullet_x` input 8, `bullet_y` input 7, `bullet_active` input 1: bullet top-left corner and visibility.
- `cnt_x` input 8, `cnt_y` input 7, `cnt_done` input 1: coordinate counter outputs.
- `cnt_enable` output 1: drives the coordinate counter's `enable`.
- `vga_x` output 8, `vga_y` output 7, `colour` output 3, `plot` output 1: write port to the VGA adapter.
- `busy` output 1: frame in progress.
- `frame_done` output 1: one-cycle pulse when the frame is complete.

## Operation
- States: IDLE and SCAN.
- IDLE, `start`=1: register the snapshot of all 7 position/visibility inputs, set `cnt_enable`<=1 and `busy`<=1, go to SCAN. `start`=0: stay in IDLE.
- SCAN, `cnt_done`=0:
  - `plot`<=1.
  - `vga_x`<=`cnt_x`, `vga_y`<=`cnt_y`.
  - `colour`<=classify(`cnt_x`,`cnt_y`) against the snapshot.
- SCAN, `cnt_done`=1:
  - `plot`<=0, `cnt_enable`<=0, `busy`<=0, `frame_done`<=1, go to IDLE.
  - The coordinate that is held while `done` is high is not plotted a second time.
- Classify, highest priority first:
  - bullet (only if `bullet_active`): 111 (white).
  - tank 1: 100 (red).
  - tank 2: 001 (blue).
  - y>=`GROUND_Y`: 010 (green).
  - otherwise: 000 (black).
- Box hit test: x>=ox and (x-ox)<W, and the same for y with H.
  - Subtraction is 9-bit/8-bit unsigned.
  - A box near the right or bottom edge clips. It never wraps to x=0 or y=0.
- Positions change only at `start`. Input changes during SCAN have no effect on the current frame.
- `frame_done` is held high for exactly one cycle. `start` arriving in that same cycle is accepted, since the block is already in IDLE.
- `start` while `busy` is dropped, not queued.

## Timing
- Reset values: `cnt_enable`=0, `plot`=0, `vga_x`=0, `vga_y`=0, `colour`=0, `busy`=0, `frame_done`=0, state IDLE, snapshot all 0.
- The counter holds (0,0) while `enable` is low and advances one coordinate per cycle while it is high.
- `start` is sampled at the edge ending cycle S.
  - `cnt_enable` and `busy` are high from S+1.
  - The counter presents pixel k (raster order, k=0..19199) in cycle S+1+k.
  - Pixel k appears on the write port with `plot`=1 in cycle S+2+k (1-cycle latency).
  - `cnt_done` is high in cycle S+19201, while the last pixel is on the write port.
  - In cycle S+19202: `plot`=0, `cnt_enable`=0, `busy`=0, `frame_done`=1.
- Total: exactly 19200 `plot` cycles per frame, contiguous, with no gaps or duplicates.
- Reset mid-frame: all outputs return to reset values immediately. `cnt_enable`=0 clears the counter on its next edge. No `frame_done` is issued.

## Test plan
- Reset, then `start` with all positions 0 and `bullet_active`=0:
  - 19200 `plot` cycles, first write (0,0) and last write (159,119).
  - Rows 0..111 outside the tank boxes are 000; rows 112..119 are 010.
  - Writes (0,0)..(7,5) are 100, since tank 1 has priority over tank 2 at the same origin.
  - `frame_done` is high exactly in cycle S+19202.
- Tank 1 at (20,30), tank 2 at (100,50):
  - Writes (20,30) and (27,35) are 100; (28,30) and (20,36) are 000.
  - Writes (100,50)..(107,55) are 001.
- Bullet at (22,31) with `bullet_active`=1, overlapping tank 1:
  - (22,31), (23,32) are 111; (24,31) is 100.
  - The same run with `bullet_active`=0 gives 100 at (22,31).
- Tank 1 at (156,117): (156..159,117..119) are 100; (0,117) and (156,0) are not red (no wrap).
- Change positions and pulse `start` at S+5000:
  - The frame still uses the old snapshot and completes at S+19202.
  - A `start` in the `frame_done` cycle starts a new frame with `cnt_enable` high the next cycle.
- Assert `reset` at S+7000:
  - `plot`, `busy`, and `cnt_enable` drop without waiting for an edge.
  - No `frame_done` is issued.
  - A following `start` renders a complete 19200-pixel frame beginning at (0,0).
